// File: rtl/regfile32.sv
// LEGv8 32-entry register file: X0-X30 in flops, X31 (XZR) reads as zero.
// Two combinational read ports with same-cycle write-to-read bypass.
module regfile32_rdport #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [4:0]                  i_idx,
  input  logic [30:0][DATA_WIDTH-1:0] i_regs,
  input  logic                        i_byp_en,
  input  logic [4:0]                  i_wr_idx,
  input  logic [DATA_WIDTH-1:0]       i_wr_data,
  input  logic                        i_rst_n,
  output logic [DATA_WIDTH-1:0]       o_data
);
  logic [DATA_WIDTH-1:0] w_sel;
  logic                  w_hit;

  // One 32:1 select per bit; source 31 is the constant-zero XZR.
  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
    logic [31:0] w_col;
    assign w_col[31] = 1'b0;
    for (genvar j = 0; j < 31; j++) begin : g_src
      assign w_col[j] = i_regs[j][b];
    end
    assign w_sel[b] = w_col[i_idx];
  end

  assign w_hit = i_byp_en && (i_idx == i_wr_idx);

  always_comb begin
    o_data = w_sel;
    if (!i_rst_n)   o_data = '0;
    else if (w_hit) o_data = i_wr_data;
  end
endmodule

module regfile32 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            read_reg1,
  input  logic [4:0]            read_reg2,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);
  localparam int NUM_PORTS = 2;

  logic [30:0][DATA_WIDTH-1:0]          r_regs;
  logic [30:0]                          w_we;
  logic                                 w_byp_en;
  logic [NUM_PORTS-1:0][4:0]            w_idx;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_rd;

  // Write decoder; index 31 has no enable, so XZR writes vanish.
  for (genvar i = 0; i < 31; i++) begin : g_dec
    assign w_we[i] = reg_write && (write_reg == 5'(i));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < 31; i++)
        if (w_we[i]) r_regs[i] <= write_data;
    end
  end

  assign w_byp_en = reg_write && reset && (write_reg != 5'd31);
  assign w_idx    = {read_reg2, read_reg1};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    regfile32_rdport #(.DATA_WIDTH(DATA_WIDTH)) u_rd (
      .i_idx    (w_idx[p]),
      .i_regs   (r_regs),
      .i_byp_en (w_byp_en),
      .i_wr_idx (write_reg),
      .i_wr_data(write_data),
      .i_rst_n  (reset),
      .o_data   (w_rd[p])
    );
  end

  assign read_data1 = w_rd[0];
  assign read_data2 = w_rd[1];
endmodule

// File: tb/tb_regfile32.sv
// Directed bench for regfile32: expected read values queued at stimulus time,
// popped and compared against both read ports.
module tb_regfile32;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [63:0] write_data;
  logic        reg_write;
  logic [63:0] read_data1, read_data2;

  typedef struct {
    string       tag;
    logic [63:0] d1;
    logic [63:0] d2;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m [32];
  int          n_vec = 0;
  int          n_err = 0;

  regfile32 #(.DATA_WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .write_data(write_data),
    .reg_write (reg_write),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m[i] = '0;
  endtask

  // Drive indices, queue expected results, then sample and compare.
  task automatic check(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [63:0] e1, input logic [63:0] e2);
    exp_t e;
    read_reg1 = r1;
    read_reg2 = r2;
    e.tag = tag; e.d1 = e1; e.d2 = e2;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_vec++;
    assert (read_data1 === e.d1)
      else begin n_err++; $error("FAIL %s rd1 observed=%h expected=%h", e.tag, read_data1, e.d1); end
    n_vec++;
    assert (read_data2 === e.d2)
      else begin n_err++; $error("FAIL %s rd2 observed=%h expected=%h", e.tag, read_data2, e.d2); end
  endtask

  task automatic wr(input logic [4:0] idx, input logic [63:0] data);
    write_reg = idx; write_data = data; reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
    if (idx != 5'd31 && reset) m[idx] = data;
  endtask

  task automatic sweep(input string tag);
    for (int k = 0; k < 31; k++)
      check(tag, 5'(k), 5'(30 - k), m[k], m[30 - k]);
  endtask

  initial begin
    reset = 1'b0; read_reg1 = '0; read_reg2 = '0;
    write_reg = '0; write_data = '0; reg_write = 1'b0;
    clear_model();
    #1;
    check("reset_state", 5'd0, 5'd30, 64'h0, 64'h0);

    // Writes while reset held low must not land or bypass.
    write_reg = 5'd5; write_data = 64'hDEAD_BEEF; reg_write = 1'b1;
    check("rst_wr_pre", 5'd5, 5'd5, 64'h0, 64'h0);
    tick();
    tick();
    check("rst_wr_post", 5'd5, 5'd5, 64'h0, 64'h0);
    reg_write = 1'b0;
    #2 reset = 1'b1;
    check("rst_release", 5'd5, 5'd5, 64'h0, 64'h0);

    for (int k = 0; k < 31; k++) wr(5'(k), 64'h1 << k);
    sweep("readback");
    check("read_x31", 5'd31, 5'd31, 64'h0, 64'h0);

    write_reg = 5'd31; write_data = '1; reg_write = 1'b1;
    check("xzr_pre", 5'd31, 5'd31, 64'h0, 64'h0);
    tick();
    reg_write = 1'b0;
    check("xzr_post", 5'd31, 5'd31, 64'h0, 64'h0);
    sweep("xzr_others");

    wr(5'd7, 64'h11);
    write_reg = 5'd7; write_data = 64'h22; reg_write = 1'b1;
    check("bypass_on", 5'd7, 5'd7, 64'h22, 64'h22);
    check("bypass_one", 5'd7, 5'd8, 64'h22, 64'h100);
    reg_write = 1'b0;
    check("bypass_off", 5'd7, 5'd7, 64'h11, 64'h11);
    tick();
    check("bypass_nowr", 5'd7, 5'd7, 64'h11, 64'h11);

    write_reg = 5'd3; write_data = 64'hABCD; reg_write = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("en_gate", 5'd3, 5'd3, 64'h8, 64'h8);
    end
    wr(5'd3, 64'hABCD);
    check("en_x3", 5'd3, 5'd3, 64'hABCD, 64'hABCD);
    check("en_x2_x4", 5'd2, 5'd4, 64'h4, 64'h10);

    write_reg = 5'd10; write_data = 64'hA; reg_write = 1'b1;
    check("b2b_first", 5'd10, 5'd10, 64'hA, 64'hA);
    tick();
    write_data = 64'hB;
    check("b2b_second", 5'd10, 5'd10, 64'hB, 64'hB);
    tick();
    reg_write = 1'b0; m[10] = 64'hB;
    check("b2b_final", 5'd10, 5'd3, 64'hB, 64'hABCD);

    wr(5'd9, 64'h55);
    check("x9_set", 5'd9, 5'd9, 64'h55, 64'h55);
    #2 reset = 1'b0;
    clear_model();
    check("async_clr", 5'd9, 5'd7, 64'h0, 64'h0);
    write_reg = 5'd9; write_data = 64'h77; reg_write = 1'b1;
    tick();
    check("rst_mid_wr", 5'd9, 5'd9, 64'h0, 64'h0);
    reg_write = 1'b0;
    #2 reset = 1'b1;
    check("x9_after", 5'd9, 5'd9, 64'h0, 64'h0);
    sweep("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile32.md
# regfile32

32-entry, DATA_WIDTH-bit general-purpose register file for the LEGv8 datapath. It is the storage stage directly upstream of the 32:1 read-select muxing. It holds X0–X30 in flip-flops with X31 (XZR) hardwired to zero, and provides two combinational read ports and one clocked write port. A same-cycle write-to-read bypass makes the decode stage see data being written back in that cycle.

## Interface
- DATA_WIDTH, 64, width of each register and of the data ports

- clk  input  1  rising-edge clock for all register state
- reset  input  1  asynchronous, active-low reset; clears X0–X30 while low
- read_reg1  input  5  register index for read port 1 (Rn)
- read_reg2  input  5  register index for read port 2 (Rm / Rt)
- write_reg  input  5  register index for the write port (Rd)
- write_data  input  DATA_WIDTH  value to write
- reg_write  input  1  write enable; sampled on rising clk
- read_data1  output  DATA_WIDTH  contents of read_reg1
- read_data2  output  DATA_WIDTH  contents of read_reg2

## Operation
- Storage: 31 registers X0–X30, each DATA_WIDTH D flip-flops with enable. X31 has no storage.
- Write decode: a 5:32 decoder on write_reg, gated by reg_write, drives the per-register enables. The decoder output for index 31 is discarded, so writes to X31 are silently dropped.
- Read path: each port selects among the 32 sources (X0–X30, constant 0 for X31) using its index. Selection is per bit, with one 32:1 select per bit per port.
- Bypass: if reg_write=1, read_regN==write_reg, write_reg!=31, and reset=1, then read_dataN=write_data combinationally. Otherwise read_dataN is the stored value.
- Both read ports are independent and may address the same register. Both may bypass in the same cycle.
- Reset: while reset=0, all of X0–X30 are held at 0 and the bypass is disabled. Both outputs are therefore 0 regardless of the indices.
- Reset releasing mid-cycle: the first write is captured at the first rising clk edge at which reset=1.
- Reset asserting mid-write: clearing wins. No register retains write_data.
- No X/undefined outputs: every 5-bit index maps to a defined source.

## Timing
- Write latency: write_data is visible in storage after the rising clk edge with reg_write=1. Through the bypass it is already visible in the same cycle, before that edge.
- Read latency: 0 cycles (combinational from read_regN, storage, and the bypass inputs).
- Reset value of outputs: read_data1=0 and read_data2=0 while reset=0. After release, all registers read 0 until written.
- Critical path: index → 32:1 select tree → bypass 2:1 → output. For gate-level builds with 50 ps gates, reads settle within 650 ps.
- Write inputs (write_reg, write_data, reg_write) must be stable for setup/hold around the rising clk edge. Read indices carry no clock constraint.
- Back-to-back writes to the same register on consecutive edges: the last one wins. Each is visible through the bypass in its own cycle.

## Test plan
- Reset: hold reset=0, write 64'hDEAD_BEEF to X5 with reg_write=1 across 2 edges, read X5 on both ports → read_data1=read_data2=0. Release reset and read X5 → 0.
- Write/readback all: for k=0..30, write 64'h1 << k to Xk on successive edges. Then sweep read_reg1=k and read_reg2=30−k → each port returns 64'h1 << its index. Reading 31 on either port → 0.
- XZR: write 64'hFFFF_FFFF_FFFF_FFFF to X31 with reg_write=1 → read 31 returns 0 both in that cycle and after the edge. No other register changes.
- Bypass: X7 holds 64'h11. Set write_reg=7, write_data=64'h22, reg_write=1, and read_reg1=read_reg2=7 → both ports show 64'h22 before the edge. With reg_write=0 and the same setup → 64'h11.
- Enable gating: set reg_write=0 and write_reg=3 with data 64'hABCD over 3 edges → X3 keeps its prior value. Then set reg_write=1 for one edge → X3=64'hABCD and X2/X4 are unchanged.
- Async reset mid-operation: X9=64'h55. Assert reset=0 between clock edges → read_data1 (read_reg1=9) drops to 0 without waiting for clk. After release, X9 reads 0.
